mem_stage_lsu: RTL
==================

# mem_stage_lsu

Memory-access stage of the RV32I pipeline. It consumes the EX/MEM pipeline register outputs and runs each load/store as a req/ack transaction on the data-memory bus. While a transaction is outstanding it stalls the upstream pipeline. It ends in the registered MEM/WB boundary that feeds register-file writeback and forwarding.

## Interface
Parameters:
- XLEN, 32, datapath width; only 32 is supported.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low.
- alu_out_i  in  XLEN  effective address, or the ALU result for non-memory instructions.
- store_data_i  in  XLEN  rs2 store data, already forwarded.
- pc_i  in  XLEN  PC of the instruction.
- instruction_i  in  XLEN  instruction word; rd = [11:7].
- reg_wr_en_i  in  1  writeback enable.
- dmem_wr_i  in  1  store.
- wb_sel_i  in  2  writeback source: 00 ALU, 01 load, 10 PC+4, 11 zero. A load is any instruction with wb_sel_i=01.
- store_size_i  in  2  store size: 00 byte, 01 half, 10 word; 11 is treated as word.
- load_size_i  in  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; any other value is treated as LW.
- dmem_req_o  out  1  bus request.
- dmem_we_o  out  1  write strobe.
- dmem_addr_o  out  XLEN  word-aligned address, {alu_out_i[31:2],2'b00}.
- dmem_be_o  out  4  byte enables.
- dmem_wdata_o  out  XLEN  lane-replicated store data.
- dmem_rdata_i  in  XLEN  read word.
- dmem_ack_i  in  1  transaction complete; sampled only while in REQ.
- stall_o  out  1  freeze PC, IF/ID, ID/EX and EX/MEM.
- wb_data_o  out  XLEN  registered writeback data.
- rd_wb_o  out  5  registered rd.
- reg_wr_en_wb_o  out  1  registered writeback enable.
- misalign_o  out  1  registered misalignment pulse (with LSU_MISALIGN_TRAP_EN only).

## Operation
- The stage has three states: IDLE, REQ and DONE.
- access = dmem_wr_i | (wb_sel_i==01).
- IDLE:
  - If access (and not trapped), go to REQ.
  - Otherwise stay in IDLE.
- REQ:
  - dmem_req_o=1, with addr, be, we and wdata held stable.
  - On dmem_ack_i=1, capture the extracted load data into an internal register and go to DONE.
- DONE: go to IDLE unconditionally.
- stall_o = (IDLE & access & ~trap) | REQ. It is 0 in DONE.
- Byte enables:
  - Byte: 0001 << addr[1:0].
  - Half: 0011 << {addr[1],1'b0}.
  - Word: 1111.
- Store data:
  - Byte: the rs2 byte replicated ×4.
  - Half: the rs2 halfword replicated ×2.
  - Word: rs2 unchanged.
- Load data: select the lane by addr[1:0] (half by addr[1]), then sign- or zero-extend per load_size_i.
- MEM/WB register:
  - Loads when stall_o=0. During a stall it loads a bubble: reg_wr_en_wb_o=0, wb_data_o=0, rd_wb_o=0.
  - wb_data source: ALU for 00, the captured load data for 01, pc_i+4 for 10 (mod 2^32), 0 for 11.
  - A store never writes back; reg_wr_en_i passes through as given.

## Timing
- Reset values: state IDLE; dmem_req_o, dmem_we_o, dmem_be_o, dmem_addr_o and dmem_wdata_o all 0; stall_o 0; wb_data_o, rd_wb_o, reg_wr_en_wb_o and misalign_o all 0.
- Non-memory instruction: the MEM/WB outputs are valid 1 cycle after the instruction is presented, with no stall.
- Memory access:
  - stall_o rises combinationally in the cycle the access is presented.
  - dmem_req_o rises on the next edge.
  - If ack arrives k cycles after req rises (k≥1, zero-wait ack in the first REQ cycle gives k=1), DONE lasts 1 cycle.
  - The writeback is visible 1 cycle after DONE.
  - Total: k+2 cycles after the access is presented; stall_o is high for k+1 cycles.
- Bus rule: dmem_req_o is deasserted in the cycle after ack. A request is never withdrawn before ack.
- Reset mid-transaction: return to IDLE immediately and drop dmem_req_o. No writeback occurs.
- Back-to-back accesses: each one passes through IDLE again, so there is at least 1 idle bus cycle between requests.

## Configuration
- LSU_MISALIGN_TRAP_EN is defined:
  - A half access with addr[0]=1 or a word access with addr[1:0]≠0 is misaligned.
  - The misaligned access issues no request and does not stall.
  - The MEM/WB register loads a bubble and misalign_o=1 for exactly 1 cycle.
- LSU_MISALIGN_TRAP_EN is undefined:
  - misalign_o is tied to 0.
  - Misaligned accesses proceed and use only the lane bits given above; low address bits are ignored for alignment.

## Test plan
- ADD result 0x0000_1234, wb_sel 00, rd 5 -> one cycle later wb_data_o=0x1234, rd_wb_o=5, reg_wr_en_wb_o=1; stall_o never asserted.
- LB at addr 0x103, rdata 0x80FF_FFFF, ack 2 cycles after req -> stall_o high 3 cycles, be=0000 on the load, wb_data_o=0xFFFF_FF80; with LBU, 0x0000_0080.
- SH at addr 0x202, rs2 0xDEAD_BEEF -> dmem_we_o=1, be=1100, wdata=0xBEEF_BEEF, addr 0x200; reg_wr_en_wb_o=0.
- JAL in MEM, pc 0xFFFF_FFFC, wb_sel 10 -> wb_data_o=0x0000_0000 (wrap).
- Reset driven low while in REQ -> dmem_req_o=0 and stall_o=0 immediately; with no access presented after reset release, state stays IDLE.
- LW at addr 0x6 with LSU_MISALIGN_TRAP_EN defined -> no dmem_req_o, stall_o=0, misalign_o=1 for 1 cycle, reg_wr_en_wb_o=0.

Source files
------------

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu: RV32I memory-access stage.
// Runs each load/store as a req/ack transaction on the data-memory bus and
// stalls upstream while it is outstanding. Ends in the MEM/WB register.
// Optional feature macro: LSU_MISALIGN_TRAP_EN (misaligned half/word accesses
// are suppressed and reported on misalign_o instead of going to the bus).
module mem_stage_lsu #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] alu_out_i,
    input  logic [XLEN-1:0] store_data_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] instruction_i,
    input  logic            reg_wr_en_i,
    input  logic            dmem_wr_i,
    input  logic [1:0]      wb_sel_i,
    input  logic [1:0]      store_size_i,
    input  logic [2:0]      load_size_i,
    output logic            dmem_req_o,
    output logic            dmem_we_o,
    output logic [XLEN-1:0] dmem_addr_o,
    output logic [3:0]      dmem_be_o,
    output logic [XLEN-1:0] dmem_wdata_o,
    input  logic [XLEN-1:0] dmem_rdata_i,
    input  logic            dmem_ack_i,
    output logic            stall_o,
    output logic [XLEN-1:0] wb_data_o,
    output logic [4:0]      rd_wb_o,
    output logic            reg_wr_en_wb_o,
    output logic            misalign_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic            req_q, req_d;
    logic            we_q, we_d;
    logic [3:0]      be_q, be_d;
    logic [XLEN-1:0] addr_q, addr_d;
    logic [XLEN-1:0] wdata_q, wdata_d;
    logic [XLEN-1:0] load_data_q, load_data_d;
    logic [XLEN-1:0] wb_data_q, wb_data_d;
    logic [4:0]      rd_wb_q, rd_wb_d;
    logic            reg_wr_en_wb_q, reg_wr_en_wb_d;
    logic            misalign_q, misalign_d;

    logic            access;
    logic            trap;
    logic            start;
    logic            stall;
    logic [3:0]      be_store;
    logic [XLEN-1:0] wdata_store;
    logic [7:0]      load_byte;
    logic [15:0]     load_half;
    logic [XLEN-1:0] load_ext;
    logic [XLEN-1:0] pc_plus4;

    // Only rd is taken from the instruction word here.
    logic unused_instr_bits;
    assign unused_instr_bits = ^{instruction_i[XLEN-1:12], instruction_i[6:0]};

    assign access   = dmem_wr_i | (wb_sel_i == 2'b01);
    assign pc_plus4 = pc_i + {{(XLEN-3){1'b0}}, 3'b100};

`ifdef LSU_MISALIGN_TRAP_EN
    logic is_byte;
    logic is_half;
    logic misaligned;

    // Classify the access width from the store or load size field.
    always_comb begin
        is_byte = 1'b0;
        is_half = 1'b0;
        if (dmem_wr_i) begin
            is_byte = (store_size_i == 2'b00);
            is_half = (store_size_i == 2'b01);
        end else begin
            is_byte = (load_size_i == 3'b000) || (load_size_i == 3'b100);
            is_half = (load_size_i == 3'b001) || (load_size_i == 3'b101);
        end
        misaligned = 1'b0;
        if (is_half)
            misaligned = alu_out_i[0];
        else if (!is_byte)
            misaligned = (alu_out_i[1:0] != 2'b00);
    end

    // A trapped access is dropped before it ever reaches the bus.
    assign trap = (state_q == S_IDLE) & access & misaligned;
`else
    assign trap = 1'b0;
`endif

    assign start = (state_q == S_IDLE) & access & ~trap;
    // Gated by reset so a held-in-reset stage never freezes the pipeline.
    assign stall   = reset & (start | (state_q == S_REQ));
    assign stall_o = stall;

    // Byte enables and lane-replicated write data for stores.
    always_comb begin
        be_store    = 4'b1111;
        wdata_store = store_data_i;
        case (store_size_i)
            2'b00: begin
                be_store    = 4'b0001 << alu_out_i[1:0];
                wdata_store = {4{store_data_i[7:0]}};
            end
            2'b01: begin
                be_store    = 4'b0011 << {alu_out_i[1], 1'b0};
                wdata_store = {2{store_data_i[15:0]}};
            end
            default: begin
                be_store    = 4'b1111;
                wdata_store = store_data_i;
            end
        endcase
    end

    // Lane select and sign/zero extension of the returned read word.
    always_comb begin
        load_byte = dmem_rdata_i[7:0];
        case (alu_out_i[1:0])
            2'b00:   load_byte = dmem_rdata_i[7:0];
            2'b01:   load_byte = dmem_rdata_i[15:8];
            2'b10:   load_byte = dmem_rdata_i[23:16];
            default: load_byte = dmem_rdata_i[31:24];
        endcase
        load_half = alu_out_i[1] ? dmem_rdata_i[31:16] : dmem_rdata_i[15:0];
        case (load_size_i)
            3'b000:  load_ext = {{(XLEN-8){load_byte[7]}}, load_byte};
            3'b001:  load_ext = {{(XLEN-16){load_half[15]}}, load_half};
            3'b100:  load_ext = {{(XLEN-8){1'b0}}, load_byte};
            3'b101:  load_ext = {{(XLEN-16){1'b0}}, load_half};
            default: load_ext = dmem_rdata_i;
        endcase
    end

    // FSM next state: IDLE -> REQ on a new access, REQ -> DONE on ack, DONE -> IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_REQ;
            S_REQ:   if (dmem_ack_i) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Bus outputs are launched on entry to REQ, held through REQ, and the
    // request/strobes drop in the cycle after ack.
    always_comb begin
        req_d       = req_q;
        we_d        = we_q;
        be_d        = be_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        load_data_d = load_data_q;
        if (start) begin
            req_d   = 1'b1;
            we_d    = dmem_wr_i;
            be_d    = dmem_wr_i ? be_store : 4'b0000;
            addr_d  = {alu_out_i[XLEN-1:2], 2'b00};
            wdata_d = wdata_store;
        end else if ((state_q == S_REQ) && dmem_ack_i) begin
            req_d       = 1'b0;
            we_d        = 1'b0;
            be_d        = 4'b0000;
            load_data_d = load_ext;
        end
    end

    // MEM/WB register: advances when not stalled, otherwise takes a bubble.
    always_comb begin
        wb_data_d      = '0;
        rd_wb_d        = 5'd0;
        reg_wr_en_wb_d = 1'b0;
        misalign_d     = trap;
        if (!stall && !trap) begin
            rd_wb_d        = instruction_i[11:7];
            reg_wr_en_wb_d = reg_wr_en_i;
            case (wb_sel_i)
                2'b00:   wb_data_d = alu_out_i;
                2'b01:   wb_data_d = load_data_q;
                2'b10:   wb_data_d = pc_plus4;
                default: wb_data_d = '0;
            endcase
        end
    end

    // State, bus and MEM/WB registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= S_IDLE;
            req_q          <= 1'b0;
            we_q           <= 1'b0;
            be_q           <= 4'b0000;
            addr_q         <= '0;
            wdata_q        <= '0;
            load_data_q    <= '0;
            wb_data_q      <= '0;
            rd_wb_q        <= 5'd0;
            reg_wr_en_wb_q <= 1'b0;
            misalign_q     <= 1'b0;
        end else begin
            state_q        <= state_d;
            req_q          <= req_d;
            we_q           <= we_d;
            be_q           <= be_d;
            addr_q         <= addr_d;
            wdata_q        <= wdata_d;
            load_data_q    <= load_data_d;
            wb_data_q      <= wb_data_d;
            rd_wb_q        <= rd_wb_d;
            reg_wr_en_wb_q <= reg_wr_en_wb_d;
            misalign_q     <= misalign_d;
        end
    end

    assign dmem_req_o     = req_q;
    assign dmem_we_o      = we_q;
    assign dmem_be_o      = be_q;
    assign dmem_addr_o    = addr_q;
    assign dmem_wdata_o   = wdata_q;
    assign wb_data_o      = wb_data_q;
    assign rd_wb_o        = rd_wb_q;
    assign reg_wr_en_wb_o = reg_wr_en_wb_q;
    assign misalign_o     = misalign_q;

endmodule
